// File: rtl/fetch_buffer_pkg.sv
// Shared decode definitions for the fetch buffer and the decode splitters.
// Holds the branch opcode, the default widths and the {pc, instr} entry type.
package fetch_buffer_pkg;

    localparam int DEPTH_DEF       = 8;
    localparam int PC_WIDTH_DEF    = 32;
    localparam int INSTR_WIDTH_DEF = 32;

    // Conditional-branch major opcode; the B-type splitter keys off the same value.
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [PC_WIDTH_DEF-1:0]    pc;
        logic [INSTR_WIDTH_DEF-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_branch_op(input logic [6:0] opcode);
        return (opcode == OPCODE_BRANCH);
    endfunction

endpackage

// File: rtl/fetch_buffer_mem.sv
// Entry storage for the fetch buffer: one synchronous write port and one
// asynchronous read port. The array is deliberately left unreset.
module fetch_buffer_mem
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = PC_WIDTH_DEF + INSTR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the accepted entry into the tail slot.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_buffer.sv
// First-word-fall-through instruction buffer between fetch and decode.
// Occupancy comes from a dedicated counter, so full/empty never depend on pointer compares.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [PC_WIDTH-1:0]      enq_pc,
    input  logic [INSTR_WIDTH-1:0]   enq_instr,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [PC_WIDTH-1:0]      deq_pc,
    output logic [INSTR_WIDTH-1:0]   deq_instr,
    output logic                     deq_is_branch,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = PC_WIDTH + INSTR_WIDTH;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             full_s;
    logic             empty_s;
    logic             enq_fire_s;
    logic             deq_fire_s;
    logic [ENT_W-1:0] wdata_s;
    logic [ENT_W-1:0] rdata_s;

    assign full_s  = (count_q == CNT_W'(DEPTH));
    assign empty_s = (count_q == {CNT_W{1'b0}});

    // Readiness ignores deq_ready: a slot freed by a dequeue is usable only next cycle.
    assign enq_ready  = ~rst & ~flush & ~full_s;
    assign deq_valid  = ~empty_s & ~flush;
    assign enq_fire_s = enq_valid & enq_ready;
    assign deq_fire_s = deq_valid & deq_ready;

    assign wdata_s = {enq_pc, enq_instr};

    fetch_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (enq_fire_s),
        .waddr_i (tail_q),
        .wdata_i (wdata_s),
        .raddr_i (head_q),
        .rdata_o (rdata_s)
    );

    assign deq_pc        = rdata_s[ENT_W-1:INSTR_WIDTH];
    assign deq_instr     = rdata_s[INSTR_WIDTH-1:0];
    assign deq_is_branch = is_branch_op(rdata_s[6:0]);
    assign count         = count_q;

    // Next-state for pointers and occupancy; flush overrides any handshake.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            if (enq_fire_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (deq_fire_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction buffer between the fetch stage and the decode splitters.
- Stores fetched {pc, instruction} pairs in a first-word-fall-through FIFO.
- Presents the head entry to decode with a valid/ready handshake.
- Discards all contents on a pipeline flush (branch mispredict or redirect).
- Also flags conditional-branch instructions at the head, so decode can steer them to the B-type field splitter without waiting.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PC_WIDTH, 32, program-counter width.
- INSTR_WIDTH, 32, instruction word width.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all buffered entries.
- enq_valid  input  1  fetch presents an entry.
- enq_ready  output  1  buffer can accept an entry this cycle.
- enq_pc  input  PC_WIDTH  PC of the presented instruction.
- enq_instr  input  INSTR_WIDTH  presented instruction word.
- deq_valid  output  1  head entry is valid.
- deq_ready  input  1  decode consumes the head this cycle.
- deq_pc  output  PC_WIDTH  PC of the head entry.
- deq_instr  output  INSTR_WIDTH  instruction word of the head entry.
- deq_is_branch  output  1  head opcode (bits 6:0) equals 7'b1100011.
- count  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (asynchronous, rst=1):
  - Head pointer, tail pointer and count go to 0 immediately.
  - deq_valid=0, enq_ready=0 while rst is asserted, count=0.
  - Storage array is not reset.
  - deq_pc, deq_instr and deq_is_branch are don't-care while deq_valid=0. The bench must not check them in that case.
- Handshakes:
  - Enqueue occurs when enq_valid & enq_ready at a rising edge.
  - Dequeue occurs when deq_valid & deq_ready at a rising edge.
  - enq_ready = !rst & !flush & (count != DEPTH). It does not depend on deq_ready, so there is no same-cycle pass-through when full.
  - deq_valid = (count != 0) & !flush.
- Latency:
  - An entry enqueued at edge N is visible on deq_* in the cycle after edge N, i.e. 1-cycle enqueue-to-visible latency.
  - deq_pc, deq_instr and deq_is_branch are combinational from head storage (first-word fall-through).
- Count update:
  - Enqueue only: count+1.
  - Dequeue only: count-1.
  - Both in the same cycle: unchanged.
  - Neither: unchanged.
- Pointers:
  - Both pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - Full and empty are derived from count, never from pointer comparison.
- Boundary conditions:
  - Full (count=DEPTH): enq_ready=0. A simultaneous dequeue frees a slot that becomes usable only from the next cycle.
  - Empty: deq_valid=0, so enqueue and a deq_ready in the same cycle produce no dequeue. The entry appears next cycle.
  - Protocol violations: enq_valid while enq_ready=0 is ignored, with no state change. deq_ready while deq_valid=0 is ignored.
- Flush:
  - Takes priority over any enqueue or dequeue in the same cycle.
  - On the following edge, head=tail=0 and count=0.
  - During the flush cycle, enq_ready=0 and deq_valid=0, so neither side sees a completed handshake.
- Reset during traffic: the buffer empties immediately and asynchronously. The first enqueue is accepted on the first edge after rst deasserts.
- Data integrity: FIFO order is preserved. PC and instruction of an entry always travel together.

Decomposition:
- Shared decode package holds:
  - OPCODE_BRANCH = 7'b1100011, shared with the B-type splitter.
  - The fetch_entry_t struct {pc, instr}.
  - The default width constants.
- One natural sub-module: fetch_buffer_mem.
  - DEPTH x (PC_WIDTH+INSTR_WIDTH) register array.
  - One synchronous write port and one asynchronous read port.
- Pointer and count logic stay in the top level.

Test Plan:
- Basic order: enqueue 3 entries (pc 0x100/0x104/0x108, instr 0x00000013/0x00208063/0x00000013), then hold deq_ready=1 -> dequeues in order. deq_is_branch is 0,1,0 and count steps 3,2,1,0.
- Fill to full: enqueue 8 entries with deq_ready=0 -> count=8 and enq_ready=0. A 9th entry with enq_valid=1 is dropped. Draining returns exactly the 8 original pcs.
- Simultaneous enq/deq at count=4 for 20 cycles -> count stays 4. Pointers wrap past index 7 and data order is unbroken.
- Flush with enq_valid=1 and deq_ready=1 at count=5 -> no handshake in that cycle, count=0 next cycle, deq_valid=0. The next enqueue (pc 0x200) appears at the head.
- Empty-cycle enqueue with deq_ready=1 -> no dequeue in that cycle. The entry is visible the next cycle with deq_valid=1.
- Assert rst asynchronously mid-cycle at count=6 -> count=0 and deq_valid=0 before the next edge. Normal operation resumes one edge after rst falls.
